// File: rtl/inst_rom_prefetch.sv
// Sequential instruction prefetcher: turns core req/gnt/rvalid fetches into
// 1-cycle-latency ROM reads and keeps a small FIFO of consecutive prefetched words.
module inst_rom_prefetch #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [31:0]           addr_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    input  logic                  flush_i,
    output logic                  rom_en_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]           rom_rdata_i
);

    // Handshake: a fetch is accepted in the cycle where req_i && gnt_o; its
    // response (rvalid_o with rdata_o/err_o) appears exactly one cycle later.
    // gnt_o is combinational and may stay low for several cycles while req_i waits.

    localparam int unsigned      CW        = $clog2(DEPTH + 1);
    localparam logic [32:0]      ROM_BYTES = 33'd1 << ADDR_WIDTH;
    localparam logic [CW:0]      DEPTH_C   = (CW + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] tag_q [DEPTH];
    logic [31:0]           data_q [DEPTH];
    logic [CW-1:0]         count_q;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] inflight_tag_q;
    logic [ADDR_WIDTH:0]   pf_addr_q;
    logic                  pf_active_q;
    logic                  rvalid_q;
    logic                  err_q;
    logic [31:0]           rdata_q;

    logic [31:0]           offset_full;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic                  hit;
    logic                  pending;
    logic                  do_oor;
    logic                  do_hit;
    logic                  do_miss;
    logic                  do_pf;
    logic                  push;
    logic                  gnt_int;
    logic [CW:0]           occupancy;
    logic [CW-1:0]         wr_idx;
    logic [ADDR_WIDTH-1:0] issue_addr;

    always_comb begin
        offset_full = addr_i - BASE_ADDR;
        in_range    = {1'b0, offset_full} < ROM_BYTES;
        offset      = {offset_full[ADDR_WIDTH-1:2], 2'b00};
        hit         = (count_q != '0) && (tag_q[0] == offset);
        // Word already requested from ROM: wait for it instead of re-missing.
        pending     = (count_q == '0) && inflight_q && (inflight_tag_q == offset);

        do_oor  = !flush_i && req_i && !in_range;
        do_hit  = !flush_i && req_i && in_range && hit;
        do_miss = !flush_i && req_i && in_range && !hit && !pending;
        gnt_int = do_oor || do_hit;

        occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(do_hit);
        // pf_addr_q top bit set means the stream ran off the end of the ROM.
        do_pf = !flush_i && !do_miss && pf_active_q && !pf_addr_q[ADDR_WIDTH]
                && (occupancy < DEPTH_C);
        push  = inflight_q && !flush_i && !do_miss;

        wr_idx     = count_q - CW'(do_hit);
        issue_addr = do_miss ? offset : pf_addr_q[ADDR_WIDTH-1:0];

        gnt_o      = gnt_int && !rst;
        rom_en_o   = (do_miss || do_pf) && !rst;
        rom_addr_o = issue_addr;
        rvalid_o   = rvalid_q;
        err_o      = err_q;
        rdata_o    = rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            count_q        <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
            pf_addr_q      <= '0;
            pf_active_q    <= 1'b0;
            rvalid_q       <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
        end else begin
            rvalid_q <= gnt_int;
            err_q    <= do_oor;
            if (gnt_int) begin
                rdata_q <= do_oor ? 32'h0 : data_q[0];
            end

            inflight_q <= do_miss || do_pf;
            if (do_miss || do_pf) begin
                inflight_tag_q <= issue_addr;
            end

            if (flush_i) begin
                pf_active_q <= 1'b0;
            end else if (do_miss) begin
                pf_active_q <= 1'b1;
                pf_addr_q   <= {1'b0, offset} + (ADDR_WIDTH + 1)'(4);
            end else if (do_pf) begin
                pf_addr_q <= pf_addr_q + (ADDR_WIDTH + 1)'(4);
            end

            if (flush_i || do_miss) begin
                count_q <= '0;
            end else begin
                if (do_hit) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        tag_q[i]  <= tag_q[i+1];
                        data_q[i] <= data_q[i+1];
                    end
                end
                // The push lands after the shift so a same-cycle pop/push is safe.
                for (int i = 0; i < DEPTH; i++) begin
                    if (push && (wr_idx == CW'(i))) begin
                        tag_q[i]  <= inflight_tag_q;
                        data_q[i] <= rom_rdata_i;
                    end
                end
                count_q <= count_q + CW'(push) - CW'(do_hit);
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_prefetch.sv
// Directed bench for inst_rom_prefetch: per-cycle vector table plus
// hand-written sequences for reset behaviour.
module tb_inst_rom_prefetch;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        flush;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [31:0] rom_rdata;

    int checks = 0;
    int errors = 0;

    inst_rom_prefetch #(
        .ADDR_WIDTH(12),
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .addr_i     (addr),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .err_o      (err),
        .flush_i    (flush),
        .rom_en_o   (rom_en),
        .rom_addr_o (rom_addr),
        .rom_rdata_i(rom_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return (a == 12'h000) ? 32'h0000_0013 : {20'hC0DE0, a};
    endfunction

    // ROM wrapper model with 1-cycle read latency.
    always @(posedge clk) begin
        rom_rdata <= rom_en ? rom_word(rom_addr) : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        flush;
        logic        gnt;
        logic        en;
        logic [11:0] ra;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [31:0] a, input logic f,
                       input logic g, input logic e, input logic [11:0] ra,
                       input logic rv, input logic er, input logic [31:0] d);
        vec_t v;
        v.req = r; v.addr = a; v.flush = f; v.gnt = g; v.en = e; v.ra = ra;
        v.rv = rv; v.err = er; v.rdata = d;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; flush = 1'b0;

        // Reset state, including a request presented during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rom_en", {31'b0, rom_en}, 32'd0);
        req = 1'b1;
        #1;
        chk("rst_gnt_with_req", {31'b0, gnt}, 32'd0);
        chk("rst_rom_en_with_req", {31'b0, rom_en}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        //   req  addr          flsh gnt en  ra      rv err rdata
        add(0, 32'h0,        0, 0, 0, 12'h000, 0, 0, 32'h0);
        add(0, 32'h0,        0, 0, 0, 12'h000, 0, 0, 32'h0);
        add(1, 32'h0,        0, 0, 1, 12'h000, 0, 0, 32'h0);          // cold miss
        add(1, 32'h0,        0, 0, 1, 12'h004, 0, 0, 32'h0);
        add(1, 32'h0,        0, 1, 1, 12'h008, 0, 0, 32'h0);
        add(1, 32'h4,        0, 1, 1, 12'h00C, 1, 0, 32'h0000_0013);
        add(1, 32'h8,        0, 1, 1, 12'h010, 1, 0, 32'hC0DE_0004);
        add(1, 32'hC,        0, 1, 1, 12'h014, 1, 0, 32'hC0DE_0008);
        add(1, 32'h100,      0, 0, 1, 12'h100, 1, 0, 32'hC0DE_000C);  // branch
        add(1, 32'h100,      0, 0, 1, 12'h104, 0, 0, 32'h0);
        add(1, 32'h100,      0, 1, 1, 12'h108, 0, 0, 32'h0);
        add(1, 32'h1000,     0, 1, 0, 12'h000, 1, 0, 32'hC0DE_0100);  // out of range
        add(1, 32'h104,      0, 1, 1, 12'h10C, 1, 1, 32'h0);
        add(0, 32'h0,        1, 0, 0, 12'h000, 1, 0, 32'hC0DE_0104);  // flush, 0x10C in flight
        add(1, 32'h108,      0, 0, 1, 12'h108, 0, 0, 32'h0);
        add(1, 32'h108,      0, 0, 1, 12'h10C, 0, 0, 32'h0);
        add(1, 32'h108,      0, 1, 1, 12'h110, 0, 0, 32'h0);
        add(1, 32'hFF8,      0, 0, 1, 12'hFF8, 1, 0, 32'hC0DE_0108);  // near ROM end
        add(1, 32'hFF8,      0, 0, 1, 12'hFFC, 0, 0, 32'h0);
        add(1, 32'hFF8,      0, 1, 0, 12'h000, 0, 0, 32'h0);
        add(1, 32'hFFC,      0, 1, 0, 12'h000, 1, 0, 32'hC0DE_0FF8);
        add(1, 32'h1000,     0, 1, 0, 12'h000, 1, 0, 32'hC0DE_0FFC);
        add(0, 32'h0,        0, 0, 0, 12'h000, 1, 1, 32'h0);
        add(0, 32'h0,        0, 0, 0, 12'h000, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].req; addr = vecs[i].addr; flush = vecs[i].flush;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), {31'b0, gnt}, {31'b0, vecs[i].gnt});
            chk($sformatf("v%0d_rom_en", i), {31'b0, rom_en}, {31'b0, vecs[i].en});
            if (vecs[i].en)
                chk($sformatf("v%0d_rom_addr", i), {20'b0, rom_addr}, {20'b0, vecs[i].ra});
            chk($sformatf("v%0d_rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].rv});
            if (vecs[i].rv) begin
                chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
                chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;

        // Reset asserted with a read in flight: state clears, fetch misses again.
        req = 1'b1; addr = 32'h20;
        @(negedge clk);
        chk("mr_miss_en", {31'b0, rom_en}, 32'd1);
        chk("mr_miss_addr", {20'b0, rom_addr}, 32'h20);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mr_gnt", {31'b0, gnt}, 32'd0);
        chk("mr_rom_en", {31'b0, rom_en}, 32'd0);
        chk("mr_rvalid", {31'b0, rvalid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_remiss_gnt", {31'b0, gnt}, 32'd0);
        chk("mr_remiss_en", {31'b0, rom_en}, 32'd1);
        chk("mr_remiss_addr", {20'b0, rom_addr}, 32'h20);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_wait_gnt", {31'b0, gnt}, 32'd0);
        chk("mr_pf_addr", {20'b0, rom_addr}, 32'h24);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_hit_gnt", {31'b0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("mr_rvalid_after", {31'b0, rvalid}, 32'd1);
        chk("mr_rdata_after", rdata, rom_word(12'h020));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
